// File: rtl/dsp_xor_stream_descrambler.sv
// dsp_xor_stream_descrambler
//   Receive-side keystream remover. Each accepted masked word is XORed with the
//   current Fibonacci-LFSR keystream word, and the keystream then advances one step.
//   A LATENCY-deep valid/ready pipeline carries the plain words to the consumer.
//   CE freezes every register. A seed load restarts the keystream and the word counter.
module dsp_xor_stream_descrambler #(
  parameter int          WIDTH   = 48,
  parameter int          LATENCY = 2,
  parameter logic [47:0] POLY    = 48'hC000_0018_0000,
  parameter logic [47:0] SEED    = 48'h0000_0000_0001
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_in_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic [15:0]      word_cnt_o
);

  generate
    if ((WIDTH < 1) || (WIDTH > 48)) begin : g_bad_width
      $error("dsp_xor_stream_descrambler: WIDTH must be in 1..48");
    end
    if ((LATENCY < 1) || (LATENCY > 2)) begin : g_bad_latency
      $error("dsp_xor_stream_descrambler: LATENCY must be in 1..2");
    end
  endgenerate

  localparam logic [WIDTH-1:0] POLY_W = POLY[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

  // One Fibonacci step: shift left and insert the tap parity at bit 0.
  // The bit loop keeps WIDTH=1 legal, where the step reduces to the parity alone.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] ks);
    logic [WIDTH-1:0] nxt;
    nxt    = {WIDTH{1'b0}};
    nxt[0] = ^(ks & POLY_W);
    for (int i = 1; i < WIDTH; i++) begin
      nxt[i] = ks[i-1];
    end
    return nxt;
  endfunction

  logic                          en_s;
  logic                          accept_s;
  logic                          deliver_s;
  logic                          load_s;
  logic [LATENCY-1:0]            vld_q, vld_d;
  logic [LATENCY-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [WIDTH-1:0]              ks_q, ks_d;
  logic [15:0]                   cnt_q, cnt_d;

  // Handshake: the pipe advances only when CE is high and the output slot can drain.
  always_comb begin
    en_s      = ce_i & (~vld_q[LATENCY-1] | m_ready_i);
    load_s    = ce_i & seed_load_i;
    s_ready_o = en_s & ~seed_load_i;
    accept_s  = s_valid_i & s_ready_o;
    deliver_s = ce_i & vld_q[LATENCY-1] & m_ready_i;
  end

  // Pipeline next state: stage 0 takes the descrambled word or a bubble, and the rest shift.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (en_s) begin
      vld_d[0] = accept_s;
      if (accept_s) begin
        dat_d[0] = s_data_i ^ ks_q;
      end else begin
        dat_d[0] = dat_q[0];
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end else begin
      vld_d = vld_q;
      dat_d = dat_q;
    end
  end

  // Keystream next state: a load forces a nonzero seed, and each accept advances one step.
  always_comb begin
    ks_d = ks_q;
    if (load_s) begin
      if (seed_in_i == {WIDTH{1'b0}}) begin
        ks_d = SEED_W;
      end else begin
        ks_d = seed_in_i;
      end
    end else if (accept_s) begin
      ks_d = lfsr_step(ks_q);
    end else begin
      ks_d = ks_q;
    end
  end

  // Delivered-word counter: a seed load clears it and takes priority over a delivery.
  // The counter saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_s) begin
      cnt_d = 16'h0000;
    end else if (deliver_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers: reset empties the pipe and returns the keystream to SEED.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= {LATENCY{1'b0}};
      dat_q <= {(LATENCY*WIDTH){1'b0}};
      ks_q  <= SEED_W;
      cnt_q <= 16'h0000;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      ks_q  <= ks_d;
      cnt_q <= cnt_d;
    end
  end

  assign m_valid_o  = vld_q[LATENCY-1];
  assign m_data_o   = dat_q[LATENCY-1];
  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_dsp_xor_stream_descrambler.sv
// Directed bench for dsp_xor_stream_descrambler.
//   u1: WIDTH=8, POLY=8'hB8, SEED=1, LATENCY=2. Its expected values are hand-derived from the
//       keystream 01,02,04,08,11,23,47,8E,...
//   u2: WIDTH=48, LATENCY=1. This instance runs a round trip against a scrambler model.
`timescale 1ns/1ps
module tb_dsp_xor_stream_descrambler;

  localparam logic [47:0] P48 = 48'hC000_0018_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ce, sl, sv, mr, sr, mv;
  logic [7:0]  sin, sd, md;
  logic [15:0] wc;
  logic        sv2, sr2, mv2;
  logic [47:0] sd2, md2;
  logic [15:0] wc2;

  int          vectors     = 0;
  int          miscompares = 0;
  int          sent;
  logic [47:0] exp_q[$];
  logic [47:0] ks2, word;
  logic [63:0] r64;

  dsp_xor_stream_descrambler #(
    .WIDTH(8), .LATENCY(2), .POLY(48'h0000_0000_00B8), .SEED(48'h0000_0000_0001)
  ) u1 (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .seed_load_i(sl), .seed_in_i(sin),
    .s_valid_i(sv), .s_ready_o(sr), .s_data_i(sd),
    .m_valid_o(mv), .m_ready_i(mr), .m_data_o(md), .word_cnt_o(wc)
  );

  dsp_xor_stream_descrambler #(
    .WIDTH(48), .LATENCY(1), .POLY(P48), .SEED(48'h0000_0000_0001)
  ) u2 (
    .clk_i(clk), .rst_i(rst), .ce_i(1'b1), .seed_load_i(1'b0), .seed_in_i(48'h0),
    .s_valid_i(sv2), .s_ready_o(sr2), .s_data_i(sd2),
    .m_valid_o(mv2), .m_ready_i(1'b1), .m_data_o(md2), .word_cnt_o(wc2)
  );

  function automatic logic [47:0] step48(input logic [47:0] k);
    return {k[46:0], ^(k & P48)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ce = 1'b1; sl = 1'b0; sin = 8'h00; sv = 1'b0; sd = 8'h00; mr = 1'b1;
    sv2 = 1'b0; sd2 = 48'h0; ks2 = 48'h1; sent = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset mv", 64'(mv), 64'h0);
    chk("reset md", 64'(md), 64'h0);
    chk("reset wc", 64'(wc), 64'h0);
    chk("reset sready", 64'(sr), 64'h1);
    chk("reset mv2", 64'(mv2), 64'h0);
    rst = 1'b0;
    tick();

    // T2: 1000 words scrambled by the bench model, with random gaps, must come back unchanged.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (mv2) begin
        if (exp_q.size() == 0) chk("T2 spurious valid", 64'(mv2), 64'h0);
        else                   chk("T2 data", 64'(md2), 64'(exp_q.pop_front()));
      end
      if ((sent >= 1000) && (exp_q.size() == 0)) break;
      if ((sent < 1000) && ($urandom_range(3, 0) != 0)) begin
        r64  = {$urandom, $urandom};
        word = r64[47:0];
        sd2  = word ^ ks2;
        sv2  = 1'b1;
        exp_q.push_back(word);
        ks2  = step48(ks2);
        sent++;
      end else begin
        sv2 = 1'b0;
      end
      tick();
    end
    sv2 = 1'b0;
    chk("T2 sent", 64'(sent), 64'd1000);
    chk("T2 drained", 64'(exp_q.size()), 64'd0);
    tick();
    chk("T2 wc", 64'(wc2), 64'd1000);
    chk("T2 idle", 64'(mv2), 64'h0);

    // T1: two back-to-back FF words give FE then FD, each 2 cycles after its accept.
    sv = 1'b1; sd = 8'hFF; tick();
    chk("T1 latency", 64'(mv), 64'h0);
    sd = 8'hFF; tick();
    sv = 1'b0;
    chk("T1 v0", 64'(mv), 64'h1);
    chk("T1 d0", 64'(md), 64'hFE);
    tick();
    chk("T1 v1", 64'(mv), 64'h1);
    chk("T1 d1", 64'(md), 64'hFD);
    tick();
    chk("T1 empty", 64'(mv), 64'h0);
    chk("T1 wc", 64'(wc), 64'd2);

    // T3: backpressure with a full pipe. The keystream is now 04, so the words are 04, 08, then AA^11=BB.
    mr = 1'b0; sv = 1'b1; sd = 8'h00; tick();
    sd = 8'h00; tick();
    sd = 8'hAA;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("T3 sready", 64'(sr), 64'h0);
      chk("T3 hold v", 64'(mv), 64'h1);
      chk("T3 hold d", 64'(md), 64'h04);
      tick();
    end
    mr = 1'b1; #1;
    chk("T3 release sready", 64'(sr), 64'h1);
    tick();
    sv = 1'b0;
    chk("T3 d1", 64'(md), 64'h08);
    tick();
    chk("T3 d2", 64'(md), 64'hBB);
    tick();
    chk("T3 empty", 64'(mv), 64'h0);
    chk("T3 wc", 64'(wc), 64'd5);

    // T4: a zero-seed load lands while a word is being delivered. The load wins the counter,
    // and the keystream returns to 01. The keystream is 23 here, so the in-flight word is 5A^23=79.
    sv = 1'b1; sd = 8'h5A; tick();
    sv = 1'b0; tick();
    chk("T4 inflight v", 64'(mv), 64'h1);
    chk("T4 inflight d", 64'(md), 64'h79);
    sl = 1'b1; sin = 8'h00; sv = 1'b1; sd = 8'h5A; #1;
    chk("T4 sready on load", 64'(sr), 64'h0);
    tick();
    chk("T4 wc cleared", 64'(wc), 64'd0);
    chk("T4 no accept", 64'(mv), 64'h0);
    sl = 1'b0; tick();
    sv = 1'b0; tick();
    chk("T4 seed word", 64'(md), 64'h5B);
    tick();
    chk("T4 wc", 64'(wc), 64'd1);
    // A nonzero seed is taken as given.
    sl = 1'b1; sin = 8'h3C; tick();
    sl = 1'b0; sv = 1'b1; sd = 8'h00; tick();
    sv = 1'b0; tick();
    chk("T4 seed_in word", 64'(md), 64'h3C);
    tick();
    chk("T4 wc reload", 64'(wc), 64'd1);

    // T5: CE low for 3 cycles, including an ignored seed load. The keystream 79,F3,E7 must be undisturbed.
    sv = 1'b1; sd = 8'h00; tick();
    tick();
    ce = 1'b0; sl = 1'b1; sin = 8'h55; #1;
    chk("T5 sready", 64'(sr), 64'h0);
    for (int k = 0; k < 3; k++) begin
      chk("T5 frozen d", 64'(md), 64'h79);
      chk("T5 frozen wc", 64'(wc), 64'd1);
      tick();
      sl = 1'b0;
    end
    ce = 1'b1; tick();
    sv = 1'b0;
    chk("T5 d1", 64'(md), 64'hF3);
    tick();
    chk("T5 d2", 64'(md), 64'hE7);
    tick();
    chk("T5 empty", 64'(mv), 64'h0);
    chk("T5 wc", 64'(wc), 64'd4);

    // T6: reset with 2 words in flight clears the outputs at once, and the keystream restarts at 01.
    sv = 1'b1; sd = 8'h00; tick();
    tick();
    sv = 1'b0;
    chk("T6 pre v", 64'(mv), 64'h1);
    rst = 1'b1; #1;
    chk("T6 async mv", 64'(mv), 64'h0);
    chk("T6 async md", 64'(md), 64'h0);
    chk("T6 async wc", 64'(wc), 64'h0);
    tick();
    rst = 1'b0;
    sv = 1'b1; sd = 8'hFF; tick();
    sv = 1'b0; tick();
    chk("T6 first v", 64'(mv), 64'h1);
    chk("T6 first d", 64'(md), 64'hFE);

    // Counter saturation: stream continuously until the counter reaches FFFF and stays there.
    sv = 1'b1; sd = 8'h00;
    repeat (65535) tick();
    chk("sat FFFE", 64'(wc), 64'hFFFE);
    tick();
    chk("sat FFFF", 64'(wc), 64'hFFFF);
    chk("sat delivering", 64'(mv), 64'h1);
    tick();
    chk("sat hold", 64'(wc), 64'hFFFF);
    sv = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
